// File: rtl/conv_mac_3_pkg.sv
// rtl/conv_mac_3_pkg.sv - shared layer-3 sizes and FSM state type for conv_mac_3
package conv_mac_3_pkg;

  // Layer-3 kernel size and coefficient width shared with the weight streamer
  localparam int KERN_S_3    = 9;
  localparam int COEFF_WIDTH = 8;
  localparam int DATA_W_3    = 16;
  localparam int SHIFT_3     = 8;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Accumulator wide enough that KERN_S full-scale products never overflow
  function automatic int acc_width(input int coeff_w, input int data_w, input int kern_s);
    return coeff_w + data_w + $clog2(kern_s);
  endfunction

endpackage

// File: rtl/conv_mac_3_if.sv
// rtl/conv_mac_3_if.sv - ap_fifo weight/pixel read ports and result write port
interface conv_mac_3_if #(
  parameter int COEFF_W = 8,
  parameter int DATA_W  = 16
) ();

  logic [COEFF_W-1:0] weight_V_dout;
  logic               weight_V_empty_n;
  logic               weight_V_read;

  logic [DATA_W-1:0]  pixel_V_dout;
  logic               pixel_V_empty_n;
  logic               pixel_V_read;

  logic [DATA_W-1:0]  output_V_din;
  logic               output_V_full_n;
  logic               output_V_write;

  // Surrounding FIFOs: supply data and status, observe pops and pushes
  modport master (
    output weight_V_dout, weight_V_empty_n,
    output pixel_V_dout, pixel_V_empty_n,
    output output_V_full_n,
    input  weight_V_read, pixel_V_read,
    input  output_V_din, output_V_write
  );

  // The MAC engine
  modport slave (
    input  weight_V_dout, weight_V_empty_n,
    input  pixel_V_dout, pixel_V_empty_n,
    input  output_V_full_n,
    output weight_V_read, pixel_V_read,
    output output_V_din, output_V_write
  );

endinterface

// File: rtl/conv_mac_3_sat_shift.sv
// rtl/conv_mac_3_sat_shift.sv - arithmetic right shift followed by signed clamp
module conv_mac_3_sat_shift #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0] din,
  output logic [OUT_W-1:0]       dout
);

  // Output range limits expressed at input width so compares stay signed
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  // Floor-shift (no rounding) then clamp into the signed output range
  always_comb begin
    shifted = din >>> SHIFT;
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_mac_3.sv
// rtl/conv_mac_3.sv - layer-3 coefficient x pixel multiply-accumulate with saturated output
module conv_mac_3
  import conv_mac_3_pkg::*;
#(
  parameter int KERN_S  = KERN_S_3,
  parameter int COEFF_W = COEFF_WIDTH,
  parameter int DATA_W  = DATA_W_3,
  parameter int SHIFT   = SHIFT_3
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  conv_mac_3_if.slave  bus
);

  localparam int ACC_W  = acc_width(COEFF_W, DATA_W, KERN_S);
  localparam int PROD_W = COEFF_W + DATA_W;
  localparam int CNT_W  = (KERN_S > 1) ? $clog2(KERN_S) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERN_S - 1);

  state_t                    state;
  state_t                    state_next;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [PROD_W-1:0]  prod;
  logic [DATA_W-1:0]         result;
  logic [DATA_W-1:0]         sat_out;
  logic                      fire;
  logic                      last;

  // A pair is consumed only when both FIFOs have data; reset masks pops
  always_comb begin
    fire = !ap_rst && (state == ACC) && bus.weight_V_empty_n && bus.pixel_V_empty_n;
    last = (cnt == CNT_LAST);
  end

  // Product and next accumulator; the first pair of a sample reloads acc
  always_comb begin
    prod     = PROD_W'($signed(bus.weight_V_dout)) * PROD_W'($signed(bus.pixel_V_dout));
    prod_ext = ACC_W'(prod);
    acc_next = (cnt == '0) ? prod_ext : (acc + prod_ext);
  end

  conv_mac_3_sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .din  (acc_next),
    .dout (sat_out)
  );

  // FSM state register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave ACC after the last pair, leave EMIT once the push lands
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (fire && last) state_next = EMIT;
      EMIT:    if (bus.output_V_full_n) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Handshake outputs; din shows the held result for the whole EMIT stay
  always_comb begin
    bus.weight_V_read  = fire;
    bus.pixel_V_read   = fire;
    bus.output_V_write = !ap_rst && (state == EMIT) && bus.output_V_full_n;
    bus.output_V_din   = result;
  end

  // Pair counter, accumulator and captured result
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (fire) begin
      acc <= acc_next;
      if (last) begin
        cnt    <= '0;
        result <= sat_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
